uart_txfsm: RTL and testbench
=============================

Name: uart_txfsm

Overview:
- UART transmit engine; directly downstream of the UART register/config block and the Tx FIFO.
- Pops bytes from the Tx FIFO and serialises them onto the line (LSB first) using the 16x baud configuration, parity mode and stop-bit count supplied by the config block.
- Contains its own 16x baud divider and bit-period counter.

Parameters:
- DIV_W, 12, width of the baud divider; matches cfg_baud_16x.

Ports:
- mclk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cfg_tx_enable  input  1  transmitter enable
- cfg_tx_stop_bit  input  1  0 -> 1 stop bit, 1 -> 2 stop bits
- cfg_pri_mod  input  2  0 -> none, 1 -> even, 2 -> odd, 3 -> treated as none
- cfg_baud_16x  input  DIV_W  16x tick period minus 1, in mclk cycles
- tx_fifo_empty  input  1  Tx FIFO empty
- tx_fifo_rd_data  input  8  FIFO head data; first-word fall-through, valid whenever !tx_fifo_empty
- tx_fifo_rd_en  output  1  single-cycle pop strobe
- so  output  1  serial data out, idle high
- tx_busy  output  1  frame in progress

Behaviour:
- Clock and reset: single clock mclk; asynchronous active-low reset_n.
- Reset values: so=1, tx_fifo_rd_en=0, tx_busy=0, state=IDLE, all counters=0, shift reg=0.
- Baud divider: div_cnt counts 0..cfg_baud_16x.
  - tick16 pulses for 1 cycle when div_cnt==cfg_baud_16x; div_cnt then returns to 0.
  - Tick period = cfg_baud_16x+1 mclk cycles. Value 0 -> tick every cycle.
- Bit counter: 4-bit tick_cnt increments on tick16. The bit boundary is tick_cnt==15 with tick16 high, giving 16 ticks per bit.
- In IDLE, div_cnt and tick_cnt are held at 0, so every start bit is exactly 16 ticks long.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: so=1. If cfg_tx_enable & !tx_fifo_empty, in that same cycle:
    - assert tx_fifo_rd_en (1 cycle);
    - latch tx_fifo_rd_data into the shift reg;
    - latch cfg_tx_stop_bit and cfg_pri_mod into frame-local copies;
    - compute the parity bit (even: ^data; odd: ~^data);
    - go to START.
  - START: so=0, tx_busy=1. At the bit boundary -> DATA, bit_idx=0.
  - DATA: so=shift[bit_idx]. At each bit boundary bit_idx++. After bit_idx==7 -> PARITY if latched mode is 1 or 2, else STOP1.
  - PARITY: so=parity bit; at the bit boundary -> STOP1.
  - STOP1: so=1; at the bit boundary -> STOP2 if latched stop=1, else IDLE.
  - STOP2: so=1; at the bit boundary -> IDLE.
- Output timing: so is registered; the first start-bit low appears the cycle after tx_fifo_rd_en.
- tx_busy: high from that cycle through the last stop-bit cycle; low in IDLE.
- Back-to-back frames: on IDLE re-entry with the FIFO non-empty, the next pop occurs on the following cycle.
  - The inter-frame gap is therefore exactly 1 mclk of idle-high beyond the stop bit(s).
- Config changes mid-frame:
  - cfg_pri_mod and cfg_tx_stop_bit changes do not affect the current frame.
  - cfg_baud_16x is not latched; a mid-frame change takes effect on the next divider wrap.
- cfg_tx_enable deasserted mid-frame: the current frame completes; no further pops.
- FIFO empty:
  - Never asserts tx_fifo_rd_en while tx_fifo_empty=1.
  - A FIFO that becomes empty mid-frame has no effect.
- Reset mid-frame: so returns high immediately (asynchronously); the byte already popped is lost.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input port cfg_tx_break (1 bit).
  - While cfg_tx_break=1 and the FSM is in IDLE, so=0 and no FIFO pops occur.
  - A break raised mid-frame takes effect once the FSM returns to IDLE.
  - On deassertion, so returns to 1 the next cycle, then normal operation resumes.
- Undefined: no port and no break logic; so is governed solely by the FSM.

Test Plan:
- baud=0, mode=0, stop=0, FIFO holds 0x55 -> one rd_en pulse; so = 0,1,0,1,0,1,0,1,0,1, each bit 16 mclk; frame lasts 160 cycles, then tx_busy=0.
- baud=3, mode=1 (even), stop=1, byte 0xA7 -> bit period 64 mclk; parity bit 1 (0xA7 has 5 ones); 2 stop bits; frame 12 bits = 768 cycles. Repeat with mode=2 -> parity bit 0.
- FIFO holds 0x00, 0xFF, 0x3C, baud=0 -> exactly 3 rd_en pulses; each subsequent start bit begins exactly 1 mclk after the previous stop-bit end; no pop while empty.
- cfg_tx_enable dropped at data bit 3 of 0x81, with 2 bytes queued -> 0x81 frame completes; no further rd_en; so stays 1; the queued byte is popped once enable is reasserted.
- reset_n asserted mid-data-bit -> so=1, tx_busy=0, tx_fifo_rd_en=0 immediately; after release, the next queued byte transmits cleanly.
- UART_TX_BREAK_EN: cfg_tx_break=1 while IDLE with FIFO non-empty -> so=0, no pops; release -> so=1 next cycle, then a normal frame starts.

Source files
------------

// File: rtl/uart_txfsm_if.sv
// Tx FIFO read handshake: the FIFO side is the slave, the transmit engine is the master.
interface uart_txfsm_if;
    logic       tx_fifo_empty;
    logic [7:0] tx_fifo_rd_data;
    logic       tx_fifo_rd_en;

    modport master (
        input  tx_fifo_empty,
        input  tx_fifo_rd_data,
        output tx_fifo_rd_en
    );

    modport slave (
        output tx_fifo_empty,
        output tx_fifo_rd_data,
        input  tx_fifo_rd_en
    );
endinterface

// File: rtl/uart_txfsm.sv
// UART transmit engine: pops bytes from the Tx FIFO and serialises start/data/parity/stop bits
// with a 16x baud divider. Optional line-break support is built when UART_TX_BREAK_EN is defined.
module uart_txfsm #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             cfg_tx_enable,
    input  logic             cfg_tx_stop_bit,
    input  logic [1:0]       cfg_pri_mod,
    input  logic [DIV_W-1:0] cfg_baud_16x,
`ifdef UART_TX_BREAK_EN
    input  logic             cfg_tx_break,
`endif
    uart_txfsm_if.master     fifo,
    output logic             so,
    output logic             tx_busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [3:0]       tick_cnt, tick_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             par_bit, par_nxt;
    logic             par_en, par_en_nxt;
    logic             stop2, stop2_nxt;
    logic             so_nxt;
    logic             pop;
    logic             tick16, bit_end;
    logic             hold_pop, idle_level;

`ifdef UART_TX_BREAK_EN
    // brk_q keeps pops off for one cycle after break release so the line shows a high mark first.
    logic brk_q;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) brk_q <= 1'b0;
        else          brk_q <= cfg_tx_break;
    end

    assign hold_pop   = cfg_tx_break | brk_q;
    assign idle_level = ~cfg_tx_break;
`else
    assign hold_pop   = 1'b0;
    assign idle_level = 1'b1;
`endif

    assign tick16  = (div_cnt == cfg_baud_16x);
    assign bit_end = tick16 && (tick_cnt == 4'd15);

    // Pop strobe is combinational in IDLE; gating with reset_n keeps it low throughout reset.
    assign fifo.tx_fifo_rd_en = pop & reset_n;

    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        tick_nxt    = tick_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        par_nxt     = par_bit;
        par_en_nxt  = par_en;
        stop2_nxt   = stop2;
        pop         = 1'b0;
        so_nxt      = 1'b1;

        if (state != IDLE) begin
            div_nxt = tick16 ? '0 : div_cnt + 1'b1;
            if (tick16) tick_nxt = tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                div_nxt     = '0;
                tick_nxt    = '0;
                bit_idx_nxt = '0;
                if (cfg_tx_enable && !fifo.tx_fifo_empty && !hold_pop) begin
                    pop        = 1'b1;
                    shift_nxt  = fifo.tx_fifo_rd_data;
                    stop2_nxt  = cfg_tx_stop_bit;
                    par_en_nxt = (cfg_pri_mod == 2'd1) || (cfg_pri_mod == 2'd2);
                    par_nxt    = (cfg_pri_mod == 2'd2) ? ~^fifo.tx_fifo_rd_data
                                                       :  ^fifo.tx_fifo_rd_data;
                    state_nxt  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = par_en ? PARITY : STOP1;
                end
            end
            PARITY: if (bit_end) state_nxt = STOP1;
            STOP1:  if (bit_end) state_nxt = stop2 ? STOP2 : IDLE;
            STOP2:  if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // so is registered from the next state so the line level lines up with the state register.
        case (state_nxt)
            IDLE:    so_nxt = idle_level;
            START:   so_nxt = 1'b0;
            DATA:    so_nxt = shift_nxt[bit_idx_nxt];
            PARITY:  so_nxt = par_nxt;
            default: so_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            stop2    <= 1'b0;
            so       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            par_bit  <= par_nxt;
            par_en   <= par_en_nxt;
            stop2    <= stop2_nxt;
            so       <= so_nxt;
            tx_busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_txfsm.sv
// Scoreboard bench for uart_txfsm: stimulus queues expected frames, a negedge monitor checks the line.
// Build with UART_TX_BREAK_EN defined to also exercise the break feature.
module tb_uart_txfsm;
    localparam int unsigned DIV_W = 12;

    logic             mclk = 1'b0;
    logic             reset_n;
    logic             cfg_tx_enable;
    logic             cfg_tx_stop_bit;
    logic [1:0]       cfg_pri_mod;
    logic [DIV_W-1:0] cfg_baud_16x;
    logic             so;
    logic             tx_busy;
    logic             brk_now;
`ifdef UART_TX_BREAK_EN
    logic             cfg_tx_break;
    assign brk_now = cfg_tx_break;
`else
    assign brk_now = 1'b0;
`endif

    uart_txfsm_if bus();

    uart_txfsm #(.DIV_W(DIV_W)) dut (
        .mclk            (mclk),
        .reset_n         (reset_n),
        .cfg_tx_enable   (cfg_tx_enable),
        .cfg_tx_stop_bit (cfg_tx_stop_bit),
        .cfg_pri_mod     (cfg_pri_mod),
        .cfg_baud_16x    (cfg_baud_16x),
`ifdef UART_TX_BREAK_EN
        .cfg_tx_break    (cfg_tx_break),
`endif
        .fifo            (bus.master),
        .so              (so),
        .tx_busy         (tx_busy)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        stop;
        int unsigned baud;
    } frame_t;

    frame_t      exp_q[$];
    logic [7:0]  byte_mem[256];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    bit          pop_seen = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // FIFO model: first-word fall-through, popped on the edge after the monitor saw rd_en
    assign bus.tx_fifo_empty   = (wr_cnt == rd_cnt);
    assign bus.tx_fifo_rd_data = byte_mem[rd_cnt % 256];

    always @(posedge mclk) rd_cnt <= rd_cnt + (pop_seen ? 1 : 0);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor / reference model
    frame_t      cur;
    logic        exp_bits[12];
    int unsigned nbits = 0, bitlen = 16, cyc = 0;
    bit          in_frame = 1'b0;
    logic        prev_brk = 1'b0;
    logic        exp_pop, idle_so;

    always @(negedge mclk) begin
        pop_seen = 1'b0;
        if (!reset_n) begin
            chk("outputs in reset", 32'({so, tx_busy, bus.tx_fifo_rd_en}), 32'(3'b100));
            in_frame = 1'b0;
        end else if (in_frame) begin
            chk($sformatf("frame %02h bit %0d", cur.data, cyc / bitlen),
                32'({so, tx_busy, bus.tx_fifo_rd_en}),
                32'({exp_bits[cyc / bitlen], 1'b1, 1'b0}));
            cyc++;
            if (cyc == nbits * bitlen) in_frame = 1'b0;
        end else begin
`ifdef UART_TX_BREAK_EN
            idle_so = ~prev_brk;
`else
            idle_so = 1'b1;
`endif
            exp_pop = cfg_tx_enable && (wr_cnt != rd_cnt) && !brk_now && !prev_brk;
            chk("idle so/busy/rd_en", 32'({so, tx_busy, bus.tx_fifo_rd_en}),
                32'({idle_so, 1'b0, exp_pop}));
            if (bus.tx_fifo_rd_en) begin
                pop_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("pop with no queued frame", 32'(exp_q.size()), 32'(1));
                end else begin
                    cur    = exp_q.pop_front();
                    bitlen = 16 * (cur.baud + 1);
                    nbits  = 0;
                    exp_bits[nbits++] = 1'b0;
                    for (int unsigned i = 0; i < 8; i++) exp_bits[nbits++] = cur.data[i];
                    if (cur.mode == 2'd1) exp_bits[nbits++] = ^cur.data;
                    if (cur.mode == 2'd2) exp_bits[nbits++] = ~^cur.data;
                    exp_bits[nbits++] = 1'b1;
                    if (cur.stop) exp_bits[nbits++] = 1'b1;
                    cyc      = 0;
                    in_frame = 1'b1;
                end
            end
        end
        prev_brk = brk_now;
    end

    task automatic push(input logic [7:0] d);
        exp_q.push_back('{d, cfg_pri_mod, cfg_tx_stop_bit, int'(cfg_baud_16x)});
        byte_mem[wr_cnt % 256] = d;
        wr_cnt++;
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge mclk);
            n++;
        end
        chk("frames drained within budget", 32'(n < budget), 32'(1));
        repeat (3) @(posedge mclk);
        #1;
    endtask

    task automatic wait_frame_start(input int unsigned budget);
        int unsigned n = 0;
        while (!in_frame && n < budget) begin
            @(posedge mclk);
            n++;
        end
        chk("frame started within budget", 32'(n < budget), 32'(1));
        #1;
    endtask

    task automatic set_cfg(input int unsigned baud, input logic [1:0] mode, input logic stop);
        cfg_baud_16x    = DIV_W'(baud);
        cfg_pri_mod     = mode;
        cfg_tx_stop_bit = stop;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nb;
        reset_n       = 1'b0;
        cfg_tx_enable = 1'b1;
        set_cfg(0, 2'd0, 1'b0);
`ifdef UART_TX_BREAK_EN
        cfg_tx_break  = 1'b0;
`endif
        repeat (3) @(posedge mclk);
        #1;
        chk("reset state", 32'({so, tx_busy, bus.tx_fifo_rd_en}), 32'(3'b100));
        reset_n = 1'b1;
        @(posedge mclk); #1;

        // single 0x55 frame, no parity, 1 stop, 16 mclk per bit
        push(8'h55);
        wait_idle(400);

        // baud=3: even then odd parity with two stop bits
        set_cfg(3, 2'd1, 1'b1);
        push(8'hA7);
        wait_idle(1000);
        set_cfg(3, 2'd2, 1'b1);
        push(8'hA7);
        wait_idle(1000);

        // three bytes back-to-back, one idle cycle between frames
        set_cfg(0, 2'd0, 1'b0);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle(800);

        // enable dropped during data bit 3 with two bytes behind it
        push(8'h81);
        push(8'h12);
        push(8'h34);
        wait_frame_start(20);
        repeat (16 * 4 + 8) @(posedge mclk);
        #1;
        cfg_tx_enable = 1'b0;
        repeat (300) @(posedge mclk);
        #1;
        chk("bytes held while disabled", 32'(wr_cnt - rd_cnt), 32'(2));
        cfg_tx_enable = 1'b1;
        wait_idle(800);

        // reset in the middle of a data bit; the popped byte is lost, the next one goes out
        push(8'h5A);
        push(8'hC3);
        wait_frame_start(20);
        repeat (16 * 5 + 7) @(posedge mclk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({so, tx_busy, bus.tx_fifo_rd_en}), 32'(3'b100));
        repeat (3) @(posedge mclk);
        #1;
        reset_n = 1'b1;
        wait_idle(400);

        // parity/stop changed mid-frame must not touch the frame in flight
        set_cfg(1, 2'd1, 1'b1);
        push(8'h6B);
        wait_frame_start(20);
        repeat (10) @(posedge mclk);
        #1;
        cfg_pri_mod     = 2'd0;
        cfg_tx_stop_bit = 1'b0;
        wait_idle(600);

        // randomized groups
        for (int unsigned g = 0; g < 8; g++) begin
            set_cfg($urandom_range(0, 2), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 3);
            for (int unsigned k = 0; k < nb; k++) push(8'($urandom));
            wait_idle(2000);
        end

`ifdef UART_TX_BREAK_EN
        // break while idle holds the line low and blocks pops
        set_cfg(0, 2'd0, 1'b0);
        cfg_tx_break = 1'b1;
        push(8'h96);
        repeat (40) @(posedge mclk);
        #1;
        chk("break blocks pop", 32'(wr_cnt - rd_cnt), 32'(1));
        cfg_tx_break = 1'b0;
        wait_idle(400);

        // break raised mid-frame only takes effect after the frame
        push(8'h3C);
        wait_frame_start(20);
        repeat (20) @(posedge mclk);
        #1;
        cfg_tx_break = 1'b1;
        push(8'hE1);
        repeat (200) @(posedge mclk);
        #1;
        chk("mid-frame break holds next byte", 32'(wr_cnt - rd_cnt), 32'(1));
        cfg_tx_break = 1'b0;
        wait_idle(400);
`endif

        chk("scoreboard empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
